// File: rtl/exec_mc_stage.sv
// Execute stage: single-cycle ALU ops plus iterative signed MUL/MULH/DIV/REM with valid/ready flow control.
// Optional EXEC_MC_EARLY_OUT_EN retires trivial long ops (zero operand, zero divisor, |dividend|<|divisor|) in one cycle.
module alu #(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        aluop,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);
  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sum, diff;
  logic [SH_W-1:0]   shamt;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result   = b;
    overflow = 1'b0;
    case (aluop)
      4'd0: begin
        result   = sum;
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      4'd1: begin
        result   = diff;
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      4'd2:    result = a & b;
      4'd3:    result = a | b;
      4'd4:    result = a ^ b;
      4'd5:    result = a << shamt;
      4'd6:    result = a >> shamt;
      4'd7:    result = DATA_W'($signed(a) >>> shamt);
      4'd8:    result = DATA_W'($signed(a) < $signed(b));
      4'd9:    result = DATA_W'(a < b);
      default: result = b;
    endcase
  end
endmodule

module exec_mc_stage #(
  parameter  int DATA_W     = 32,
  parameter  int REG_ADDR_W = 5,
  parameter  int FWD_SRCS   = 3,
  localparam int SEL_W      = $clog2(FWD_SRCS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 op,
  input  logic                       alusrc,
  input  logic [DATA_W-1:0]          reg1_data,
  input  logic [DATA_W-1:0]          reg2_data,
  input  logic [DATA_W-1:0]          immediat,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_data,
  input  logic [SEL_W-1:0]           fwd_sel1,
  input  logic [SEL_W-1:0]           fwd_sel2,
  input  logic [REG_ADDR_W-1:0]      dst_reg_in,
  input  logic                       regwrite_in,
  input  logic                       do_read,
  input  logic                       do_write,
  input  logic                       is_byte,
  input  logic                       memtoreg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          alu_result,
  output logic [DATA_W-1:0]          data_store,
  output logic                       zero,
  output logic                       overflow,
  output logic [REG_ADDR_W-1:0]      dst_reg,
  output logic                       regwrite_out,
  output logic                       do_read_out,
  output logic                       do_write_out,
  output logic                       is_byte_out,
  output logic                       memtoreg_out,
  output logic                       busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [1:0] L_MUL = 2'd0, L_MULH = 2'd1, L_DIV = 2'd2;
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic [0:0]            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DATA_W-1:0]     acc_hi_reg, acc_lo_reg, mag_b_reg;
  logic                  sign_a_reg, sign_b_reg, div_ovf_reg;
  logic [1:0]            lop_reg;
  logic [REG_ADDR_W-1:0] p_dst_reg;
  logic [4:0]            p_sb_reg;
  logic [DATA_W-1:0]     p_store_reg;
  logic                  out_valid_reg, zero_reg, overflow_reg;
  logic [DATA_W-1:0]     result_reg, store_reg;
  logic [REG_ADDR_W-1:0] dst_out_reg;
  logic [4:0]            sb_out_reg;

  // Unpack the flat forward buses; index k of fwd_bus is selected by select value k+1.
  logic [DATA_W-1:0] fwd_bus [FWD_SRCS];
  generate
    for (genvar gi = 0; gi < FWD_SRCS; gi++) begin : g_fwd
      assign fwd_bus[gi] = fwd_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [DATA_W-1:0] opnd1, fwd2, opnd2;
  always_comb begin
    opnd1 = '0;
    fwd2  = '0;
    if (fwd_sel1 == '0) opnd1 = reg1_data;
    if (fwd_sel2 == '0) fwd2 = reg2_data;
    for (int k = 1; k <= FWD_SRCS; k++) begin
      if (fwd_sel1 == SEL_W'(k)) opnd1 = fwd_bus[k-1];
      if (fwd_sel2 == SEL_W'(k)) fwd2 = fwd_bus[k-1];
    end
  end
  assign opnd2 = alusrc ? fwd2 : immediat;

  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  alu #(.DATA_W(DATA_W)) u_alu (
    .aluop    (op[3:0]),
    .a        (opnd1),
    .b        (opnd2),
    .result   (alu_res),
    .overflow (alu_ovf)
  );

  logic              sign_a, sign_b;
  logic [DATA_W-1:0] mag_a, mag_b;
  assign sign_a = opnd1[DATA_W-1];
  assign sign_b = opnd2[DATA_W-1];
  assign mag_a  = sign_a ? -opnd1 : opnd1;
  assign mag_b  = sign_b ? -opnd2 : opnd2;

  logic              early_hit;
  logic [DATA_W-1:0] early_res;
`ifdef EXEC_MC_EARLY_OUT_EN
  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (op[4]) begin
      if (!op[1]) begin
        early_hit = (opnd1 == '0) || (opnd2 == '0);
      end else if (opnd2 == '0) begin
        early_hit = 1'b1;
        early_res = op[0] ? opnd1 : {DATA_W{1'b1}};
      end else if (mag_a < mag_b) begin
        early_hit = 1'b1;
        early_res = op[0] ? opnd1 : '0;
      end
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_res = '0;
`endif

  // One shift-add (acc_lo holds multiplier bits) or restoring-divide step (acc_lo holds quotient).
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic [DATA_W-1:0] step_hi, step_lo;
  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mag_b_reg} : '0);
    div_shift = {acc_hi_reg, acc_lo_reg[DATA_W-1]};
    div_diff  = div_shift - {1'b0, mag_b_reg};
    if (!lop_reg[1]) begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], acc_lo_reg[DATA_W-1:1]};
    end else if (!div_diff[DATA_W]) begin
      step_hi = div_diff[DATA_W-1:0];
      step_lo = {acc_lo_reg[DATA_W-2:0], 1'b1};
    end else begin
      step_hi = div_shift[DATA_W-1:0];
      step_lo = {acc_lo_reg[DATA_W-2:0], 1'b0};
    end
  end

  // Sign correction runs from the settled accumulators in an extra BUSY cycle.
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   long_res;
  logic                long_ovf;
  always_comb begin
    prod_s = (sign_a_reg ^ sign_b_reg) ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};
    case (lop_reg)
      L_MUL:   long_res = prod_s[DATA_W-1:0];
      L_MULH:  long_res = prod_s[2*DATA_W-1:DATA_W];
      L_DIV:   long_res = (mag_b_reg == '0) ? {DATA_W{1'b1}} :
                          ((sign_a_reg ^ sign_b_reg) ? -acc_lo_reg : acc_lo_reg);
      default: long_res = sign_a_reg ? -acc_hi_reg : acc_hi_reg;
    endcase
    long_ovf = (lop_reg == L_DIV) && div_ovf_reg;
  end

  logic accept, load_short, start_long, load_long;
  assign in_ready   = (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept     = in_valid && in_ready && !flush;
  assign load_short = accept && (!op[4] || early_hit);
  assign start_long = accept && op[4] && !early_hit;
  assign load_long  = (state_reg == BUSY) && (cnt_reg == CNT_LAST);

  logic [DATA_W-1:0]     ld_result, ld_store;
  logic                  ld_ovf;
  logic [REG_ADDR_W-1:0] ld_dst;
  logic [4:0]            ld_sb;
  always_comb begin
    ld_result = long_res;
    ld_ovf    = long_ovf;
    ld_dst    = p_dst_reg;
    ld_sb     = p_sb_reg;
    ld_store  = p_store_reg;
    if (load_short) begin
      ld_result = op[4] ? early_res : alu_res;
      ld_ovf    = !op[4] && alu_ovf;
      ld_dst    = dst_reg_in;
      ld_sb     = {regwrite_in, do_read, do_write, is_byte, memtoreg};
      ld_store  = fwd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_hi_reg    <= '0;
      acc_lo_reg    <= '0;
      mag_b_reg     <= '0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      div_ovf_reg   <= 1'b0;
      lop_reg       <= '0;
      p_dst_reg     <= '0;
      p_sb_reg      <= '0;
      p_store_reg   <= '0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      store_reg     <= '0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      dst_out_reg   <= '0;
      sb_out_reg    <= '0;
    end else if (flush) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      sb_out_reg    <= '0;
    end else begin
      if (start_long) begin
        state_reg   <= BUSY;
        cnt_reg     <= '0;
        acc_hi_reg  <= '0;
        acc_lo_reg  <= mag_a;
        mag_b_reg   <= mag_b;
        sign_a_reg  <= sign_a;
        sign_b_reg  <= sign_b;
        lop_reg     <= op[1:0];
        div_ovf_reg <= (opnd1 == MIN_VAL) && (opnd2 == {DATA_W{1'b1}});
        p_dst_reg   <= dst_reg_in;
        p_sb_reg    <= {regwrite_in, do_read, do_write, is_byte, memtoreg};
        p_store_reg <= fwd2;
      end else if (state_reg == BUSY) begin
        if (load_long) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          acc_hi_reg <= step_hi;
          acc_lo_reg <= step_lo;
          cnt_reg    <= cnt_reg + CNT_W'(1);
        end
      end
      if (load_short || load_long) begin
        out_valid_reg <= 1'b1;
        result_reg    <= ld_result;
        store_reg     <= ld_store;
        zero_reg      <= (ld_result == '0);
        overflow_reg  <= ld_ovf;
        dst_out_reg   <= ld_dst;
        sb_out_reg    <= ld_sb;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign alu_result   = result_reg;
  assign data_store   = store_reg;
  assign zero         = zero_reg;
  assign overflow     = overflow_reg;
  assign dst_reg      = dst_out_reg;
  assign regwrite_out = sb_out_reg[4];
  assign do_read_out  = sb_out_reg[3];
  assign do_write_out = sb_out_reg[2];
  assign is_byte_out  = sb_out_reg[1];
  assign memtoreg_out = sb_out_reg[0];
  assign busy         = (state_reg == BUSY);
endmodule

// File: tb/tb_exec_mc_stage.sv
// Directed bench for exec_mc_stage (DATA_W=32, FWD_SRCS=4 so SEL_W=3); honours EXEC_MC_EARLY_OUT_EN.
module tb_exec_mc_stage;
  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01;
  localparam logic [4:0] OP_MUL = 5'h10, OP_MULH = 5'h11, OP_DIV = 5'h12, OP_REM = 5'h13;
`ifdef EXEC_MC_EARLY_OUT_EN
  localparam int LE = 0;
`else
  localparam int LE = 33;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, flush, in_valid, in_ready, alusrc, out_valid, out_ready;
  logic [4:0]   op, dst_reg_in, dst_reg;
  logic [31:0]  reg1_data, reg2_data, immediat, alu_result, data_store;
  logic [127:0] fwd_data;
  logic [2:0]   fwd_sel1, fwd_sel2;
  logic regwrite_in, do_read, do_write, is_byte, memtoreg;
  logic regwrite_out, do_read_out, do_write_out, is_byte_out, memtoreg_out;
  logic zero, overflow, busy;

  int n_cmp = 0;
  int n_bad = 0;

  exec_mc_stage #(.DATA_W(32), .REG_ADDR_W(5), .FWD_SRCS(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .alusrc(alusrc), .reg1_data(reg1_data), .reg2_data(reg2_data), .immediat(immediat),
    .fwd_data(fwd_data), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .dst_reg_in(dst_reg_in),
    .regwrite_in(regwrite_in), .do_read(do_read), .do_write(do_write), .is_byte(is_byte),
    .memtoreg(memtoreg), .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .data_store(data_store), .zero(zero), .overflow(overflow), .dst_reg(dst_reg),
    .regwrite_out(regwrite_out), .do_read_out(do_read_out), .do_write_out(do_write_out),
    .is_byte_out(is_byte_out), .memtoreg_out(memtoreg_out), .busy(busy)
  );

  task automatic set_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; reg1_data = a; reg2_data = b; alusrc = 1'b1; immediat = '0;
    fwd_sel1 = '0; fwd_sel2 = '0; dst_reg_in = 5'd9;
    regwrite_in = 1'b1; do_read = 1'b0; do_write = 1'b1; is_byte = 1'b1; memtoreg = 1'b0;
  endtask

  // Presents the op for one edge; returns at the following negedge with in_valid dropped.
  task automatic accept_one();
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid; -1 when the bound expires.
  task automatic wait_result(output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); @(negedge clk);
      edges++;
    end
    if (!out_valid) edges = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fwd_data = '0;
    set_op(OP_ADD, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (alu_result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", alu_result); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if ({dst_reg, regwrite_out, do_write_out, is_byte_out} !== 8'd0) begin
      n_bad++; $display("FAIL reset_sideband got %h want 0", {dst_reg, regwrite_out, do_write_out, is_byte_out});
    end
    $display("reset released: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  task automatic test_short_alu();
    set_op(OP_ADD, 32'd5, 32'd7);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready_before got %b want 1", in_ready); end
    accept_one();
    $display("ADD 5+7 -> valid=%b result=%h", out_valid, alu_result);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b want 1", out_valid); end
    n_cmp++; if (alu_result !== 32'd12) begin n_bad++; $display("FAIL add_result got %h want 0000000c", alu_result); end
    n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL add_zero got %b want 0", zero); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready_after got %b want 1", in_ready); end
    n_cmp++; if ({dst_reg, regwrite_out, do_read_out, do_write_out, is_byte_out, memtoreg_out} !== {5'd9, 5'b10110}) begin
      n_bad++; $display("FAIL add_sideband got %h want 136", {dst_reg, regwrite_out, do_read_out, do_write_out, is_byte_out, memtoreg_out});
    end
    // Back-to-back accepts keep out_valid high while new results load.
    set_op(OP_SUB, 32'd7, 32'd7);
    accept_one();
    $display("SUB 7-7 -> valid=%b result=%h zero=%b", out_valid, alu_result, zero);
    n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'd0) begin n_bad++; $display("FAIL sub_result got %b/%h want 1/00000000", out_valid, alu_result); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL sub_zero got %b want 1", zero); end
    set_op(OP_ADD, 32'h7fffffff, 32'd1);
    accept_one();
    $display("ADD 7fffffff+1 -> result=%h ovf=%b", alu_result, overflow);
    n_cmp++; if (alu_result !== 32'h80000000) begin n_bad++; $display("FAIL addovf_result got %h want 80000000", alu_result); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL addovf_flag got %b want 1", overflow); end
  endtask

  task automatic test_mul_timing();
    int edges;
    int stall_bad;
    drain();
    set_op(OP_MUL, 32'hffffffff, 32'd3);
    dst_reg_in = 5'd17;
    accept_one();
    edges = 0; stall_bad = 0;
    while (!out_valid && edges < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) stall_bad++;
      @(posedge clk); @(negedge clk);
      edges++;
    end
    if (!out_valid) edges = -1;
    $display("MUL ffffffff*3 -> edges=%0d result=%h", edges, alu_result);
    n_cmp++; if (edges != 33) begin n_bad++; $display("FAIL mul_latency got %0d want 33", edges); end
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL mul_stall got %0d bad cycles want 0", stall_bad); end
    n_cmp++; if (alu_result !== 32'hfffffffd) begin n_bad++; $display("FAIL mul_result got %h want fffffffd", alu_result); end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL mul_done_state got busy=%b ready=%b want 0/1", busy, in_ready); end
    n_cmp++; if (dst_reg !== 5'd17 || do_write_out !== 1'b1) begin n_bad++; $display("FAIL mul_sideband got %0d/%b want 17/1", dst_reg, do_write_out); end
  endtask

  localparam int NL = 12;
  logic [4:0]  l_op  [NL] = '{OP_MULH, OP_DIV, OP_REM, OP_DIV, OP_DIV, OP_REM,
                             OP_DIV, OP_REM, OP_DIV, OP_MUL, OP_MULH, OP_MUL};
  logic [31:0] l_a   [NL] = '{32'hffffffff, 32'hfffffff9, 32'hfffffff9, 32'h80000000, 32'd5, 32'd5,
                             32'd100, 32'hffffff9c, 32'd3, 32'd1234, 32'h80000000, 32'd7};
  logic [31:0] l_b   [NL] = '{32'd3, 32'd2, 32'd2, 32'hffffffff, 32'd0, 32'd0,
                             32'd7, 32'd7, 32'hfffffff6, 32'd0, 32'h80000000, 32'hfffffffa};
  logic [31:0] l_exp [NL] = '{32'hffffffff, 32'hfffffffd, 32'hffffffff, 32'h80000000, 32'hffffffff, 32'd5,
                             32'd14, 32'hfffffffe, 32'd0, 32'd0, 32'h40000000, 32'hffffffd6};
  logic        l_ovf [NL] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int          l_lat [NL] = '{33, 33, 33, 33, LE, LE, 33, 33, LE, LE, 33, 33};

  task automatic test_long_ops();
    int edges;
    for (int i = 0; i < NL; i++) begin
      drain();
      set_op(l_op[i], l_a[i], l_b[i]);
      accept_one();
      wait_result(edges);
      $display("long op %h a=%h b=%h -> edges=%0d result=%h ovf=%b zero=%b",
               l_op[i], l_a[i], l_b[i], edges, alu_result, overflow, zero);
      n_cmp++; if (alu_result !== l_exp[i]) begin n_bad++; $display("FAIL long%0d_result got %h want %h", i, alu_result, l_exp[i]); end
      n_cmp++; if (overflow !== l_ovf[i]) begin n_bad++; $display("FAIL long%0d_ovf got %b want %b", i, overflow, l_ovf[i]); end
      n_cmp++; if (zero !== (l_exp[i] == 32'd0)) begin n_bad++; $display("FAIL long%0d_zero got %b want %b", i, zero, l_exp[i] == 32'd0); end
      n_cmp++; if (edges != l_lat[i]) begin n_bad++; $display("FAIL long%0d_latency got %0d want %0d", i, edges, l_lat[i]); end
    end
  endtask

  localparam int NF = 6;
  logic [2:0]  f_sel [NF] = '{3'd2, 3'd7, 3'd5, 3'd4, 3'd1, 3'd0};
  logic [31:0] f_exp [NF] = '{32'h14, 32'h4, 32'h4, 32'h59, 32'h1115, 32'h99d};

  task automatic test_forward();
    drain();
    fwd_data = {32'h00000055, 32'habcd0002, 32'h00000010, 32'h00001111};
    for (int i = 0; i < NF; i++) begin
      set_op(OP_ADD, 32'h999, 32'h888);
      alusrc = 1'b0; immediat = 32'd4; fwd_sel1 = f_sel[i]; fwd_sel2 = 3'd3;
      accept_one();
      $display("fwd sel1=%0d imm=4 -> result=%h store=%h", f_sel[i], alu_result, data_store);
      n_cmp++; if (alu_result !== f_exp[i]) begin n_bad++; $display("FAIL fwd%0d_result got %h want %h", i, alu_result, f_exp[i]); end
      n_cmp++; if (data_store !== 32'habcd0002) begin n_bad++; $display("FAIL fwd%0d_store got %h want abcd0002", i, data_store); end
    end
    set_op(OP_ADD, 32'h999, 32'h888);
    fwd_sel2 = 3'd6;
    accept_one();
    $display("fwd sel2=6 -> result=%h store=%h", alu_result, data_store);
    n_cmp++; if (alu_result !== 32'h999 || data_store !== 32'd0) begin
      n_bad++; $display("FAIL fwd_sel2_range got %h/%h want 00000999/00000000", alu_result, data_store);
    end
  endtask

  task automatic test_backpressure();
    drain();
    out_ready = 1'b0;
    set_op(OP_ADD, 32'd1, 32'd2);
    accept_one();
    set_op(OP_ADD, 32'd10, 32'd20);
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'd3) begin n_bad++; $display("FAIL hold_result got %b/%h want 1/00000003", out_valid, alu_result); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready got %b want 0", in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    $display("queued ADD 10+20 -> valid=%b result=%h", out_valid, alu_result);
    n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'd30) begin n_bad++; $display("FAIL queued_result got %b/%h want 1/0000001e", out_valid, alu_result); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL consume_valid got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    int seen;
    drain();
    set_op(OP_DIV, 32'd100, 32'd7);
    accept_one();
    repeat (10) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    $display("flush in DIV -> busy=%b ready=%b valid=%b", busy, in_ready, out_valid);
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_busy got busy=%b ready=%b want 0/1", busy, in_ready); end
    seen = 0;
    repeat (40) begin
      if (out_valid !== 1'b0) seen++;
      @(posedge clk); @(negedge clk);
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
    set_op(OP_ADD, 32'd1, 32'd1);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_drop got %b want 0", out_valid); end
    out_ready = 1'b0;
    set_op(OP_ADD, 32'd2, 32'd2);
    accept_one();
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    $display("flush pending -> valid=%b regwrite=%b ready=%b", out_valid, regwrite_out, in_ready);
    n_cmp++; if (out_valid !== 1'b0 || regwrite_out !== 1'b0 || do_write_out !== 1'b0) begin
      n_bad++; $display("FAIL flush_pending got %b/%b/%b want 0/0/0", out_valid, regwrite_out, do_write_out);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_short_alu();
    test_mul_timing();
    test_long_ops();
    test_forward();
    test_backpressure();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
